// File: rtl/riscv_defines.sv
// Shared encodings for the multi-cycle RISC-V core: FSM states, opcodes and
// datapath select values driven by the main controller.
package riscv_defines;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWRITE = 4'd4,
        S_MEMWB    = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [1:0] SRC_A_PC    = 2'b00;
    localparam logic [1:0] SRC_A_OLDPC = 2'b01;
    localparam logic [1:0] SRC_A_RS1   = 2'b10;

    localparam logic [1:0] SRC_B_RS2  = 2'b00;
    localparam logic [1:0] SRC_B_IMM  = 2'b01;
    localparam logic [1:0] SRC_B_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_RDATA     = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/multi_cycle_controller.sv
// Main control FSM of the multi-cycle RISC-V core: sequences each instruction,
// drives all datapath selects/enables and counts retired instructions.
module multi_cycle_controller
    import riscv_defines::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [6:0]           op,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 mem_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [1:0]           alu_op,
    output logic                 instr_retired,
    output logic                 illegal_instr,
    output logic [CNT_WIDTH-1:0] instret
);

    state_t state, next_state;
    logic   pc_update;
    logic   branch;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= next_state;
            if (instr_retired) begin
                instret <= instret + CNT_WIDTH'(1);
            end
        end
    end

    assign pc_write = pc_update | (branch & zero);

    always_comb begin
        next_state    = state;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_update     = 1'b0;
        branch        = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_RS2;
        result_src    = RES_ALUOUT;
        alu_op        = ALUOP_ADD;
        instr_retired = 1'b0;
        illegal_instr = 1'b0;

        case (state)
            S_FETCH: begin
                alu_src_b  = SRC_B_FOUR;
                result_src = RES_ALURESULT;
                ir_write   = mem_ready;
                pc_update  = mem_ready;
                if (mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                // Branch target is precomputed here from old_pc + imm.
                alu_src_a = SRC_A_OLDPC;
                alu_src_b = SRC_B_IMM;
                case (op)
                    OP_LW, OP_SW: next_state = S_MEMADR;
                    OP_R:         next_state = S_EXECUTER;
                    OP_I:         next_state = S_EXECUTEI;
                    OP_BEQ:       next_state = S_BEQ;
                    OP_JAL:       next_state = S_JAL;
                    default:      next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                next_state = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src = 1'b1;
                if (mem_ready) next_state = S_MEMWB;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = mem_ready;
                if (mem_ready) begin
                    next_state    = S_FETCH;
                    instr_retired = 1'b1;
                end
            end
            S_MEMWB: begin
                result_src    = RES_RDATA;
                reg_write     = 1'b1;
                next_state    = S_FETCH;
                instr_retired = 1'b1;
            end
            S_EXECUTER: begin
                alu_src_a  = SRC_A_RS1;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a  = SRC_A_RS1;
                alu_src_b  = SRC_B_IMM;
                alu_op     = ALUOP_FUNCT;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write     = 1'b1;
                next_state    = S_FETCH;
                instr_retired = 1'b1;
            end
            S_BEQ: begin
                alu_src_a     = SRC_A_RS1;
                alu_op        = ALUOP_SUB;
                branch        = 1'b1;
                next_state    = S_FETCH;
                instr_retired = 1'b1;
            end
            S_JAL: begin
                // Jump target goes to pc now; ALUWB then writes the link value.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_FOUR;
                pc_update  = 1'b1;
                next_state = S_ALUWB;
            end
            S_TRAP: begin
                illegal_instr = 1'b1;
                next_state    = S_TRAP;
            end
            default: begin
                illegal_instr = 1'b1;
                next_state    = S_TRAP;
            end
        endcase
    end

endmodule

// File: tb/tb_multi_cycle_controller.sv
// Directed bench for multi_cycle_controller with a 4-bit retire counter so the
// counter wrap can be reached quickly.
module tb_multi_cycle_controller;
    import riscv_defines::*;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [6:0]    op;
    logic          zero;
    logic          mem_ready;
    logic          adr_src, ir_write, pc_write, mem_write, reg_write;
    logic [1:0]    alu_src_a, alu_src_b, result_src, alu_op;
    logic          instr_retired, illegal_instr;
    logic [CW-1:0] instret;

    int tests  = 0;
    int failed = 0;

    multi_cycle_controller #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .mem_write(mem_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_op(alu_op),
        .instr_retired(instr_retired), .illegal_instr(illegal_instr),
        .instret(instret)
    );

    always #5 clk = ~clk;

    // Observed output bundle: adr,irw,pcw,mw,rw,srcA,srcB,res,aluop,ret,ill
    logic [14:0] outv;
    assign outv = {adr_src, ir_write, pc_write, mem_write, reg_write, alu_src_a,
                   alu_src_b, result_src, alu_op, instr_retired, illegal_instr};

    function automatic logic [14:0] ov(input logic adr, irw, pcw, mw, rw,
                                       input logic [1:0] sa, sb, rs, aop,
                                       input logic ret, ill);
        return {adr, irw, pcw, mw, rw, sa, sb, rs, aop, ret, ill};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_r(input int n);
        op = OP_R;
        for (int i = 0; i < n; i++) begin
            repeat (4) tick();
        end
    endtask

    initial begin
        reset = 1'b1; op = 7'd0; zero = 1'b0; mem_ready = 1'b1;
        tick(); tick();
        chk("rst_state", dut.state, S_FETCH);
        chk("rst_out", outv, ov(0,1,1,0,0,2'b00,2'b10,2'b10,2'b00,0,0));
        chk("rst_instret", instret, 0);
        reset = 1'b0;

        // R-type, 4 cycles
        op = OP_R;
        tick(); chk("r_decode", outv, ov(0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,0,0));
        tick(); chk("r_exec",   outv, ov(0,0,0,0,0,2'b10,2'b00,2'b00,2'b10,0,0));
        tick(); chk("r_aluwb",  outv, ov(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0));
        chk("r_instret_pre", instret, 0);
        tick(); chk("r_state", dut.state, S_FETCH);
        chk("r_instret", instret, 1);

        // FETCH waits on mem_ready with no enables
        mem_ready = 1'b0; #1;
        chk("fetch_wait", outv, ov(0,0,0,0,0,2'b00,2'b10,2'b10,2'b00,0,0));
        tick(); chk("fetch_hold", dut.state, S_FETCH);
        mem_ready = 1'b1;

        // Load with 3 wait cycles in MEMREAD: 8 cycles
        op = OP_LW;
        tick(); chk("lw_decode", dut.state, S_DECODE);
        tick(); chk("lw_memadr", outv, ov(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,0,0));
        tick(); mem_ready = 1'b0; #1;
        chk("lw_memread", outv, ov(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0));
        tick(); chk("lw_wait2", dut.state, S_MEMREAD);
        tick(); chk("lw_wait3", dut.state, S_MEMREAD);
        mem_ready = 1'b1; #1;
        chk("lw_rd_last", outv, ov(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0));
        tick(); chk("lw_memwb", outv, ov(0,0,0,0,1,2'b00,2'b00,2'b01,2'b00,1,0));
        tick(); chk("lw_state", dut.state, S_FETCH);
        chk("lw_instret", instret, 2);

        // Store with one wait cycle
        op = OP_SW;
        tick(); tick(); tick(); mem_ready = 1'b0; #1;
        chk("sw_wait", outv, ov(1,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,0));
        mem_ready = 1'b1; #1;
        chk("sw_write", outv, ov(1,0,0,1,0,2'b00,2'b00,2'b00,2'b00,1,0));
        tick(); chk("sw_state", dut.state, S_FETCH);
        chk("sw_instret", instret, 3);

        // BEQ taken then not taken
        op = OP_BEQ; zero = 1'b1;
        tick(); tick();
        chk("beq_taken", outv, ov(0,0,1,0,0,2'b10,2'b00,2'b00,2'b01,1,0));
        tick(); chk("beq_t_state", dut.state, S_FETCH);
        zero = 1'b0;
        tick(); tick();
        chk("beq_ntaken", outv, ov(0,0,0,0,0,2'b10,2'b00,2'b00,2'b01,1,0));
        tick(); chk("beq_instret", instret, 5);

        // JAL then link writeback
        op = OP_JAL;
        tick(); tick();
        chk("jal", outv, ov(0,0,1,0,0,2'b01,2'b10,2'b00,2'b00,0,0));
        tick(); chk("jal_aluwb", outv, ov(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,1,0));
        tick(); chk("jal_instret", instret, 6);

        // I-type
        op = OP_I;
        tick(); tick();
        chk("i_exec", outv, ov(0,0,0,0,0,2'b10,2'b01,2'b00,2'b10,0,0));
        tick(); tick(); chk("i_instret", instret, 7);

        // Illegal opcode traps until reset
        op = 7'b1111111;
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            chk("trap_out", outv, ov(0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,0,1));
            tick();
        end
        chk("trap_instret", instret, 7);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("trap_rst", dut.state, S_FETCH);
        chk("trap_rst_cnt", instret, 0);

        // Counter wrap
        run_r(15);
        chk("cnt_max", instret, 4'hF);
        run_r(1);
        chk("cnt_wrap", instret, 0);

        // Reset in the retire cycle blocks the increment
        run_r(1);
        chk("cnt_one", instret, 1);
        tick(); tick(); tick();
        chk("pre_rst_ret", instr_retired, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_ret_state", dut.state, S_FETCH);
        chk("rst_ret_cnt", instret, 0);

        // Reset during EXECUTEI
        op = OP_I;
        tick(); tick();
        chk("ei_state", dut.state, S_EXECUTEI);
        reset = 1'b1; tick(); reset = 1'b0; #1;
        chk("ei_rst_state", dut.state, S_FETCH);
        chk("ei_rst_ret", instr_retired, 0);
        chk("ei_rst_cnt", instret, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/multi_cycle_controller.md
Name: multi_cycle_controller

Overview:
Main control FSM for the multi-cycle RISC-V core: sequences one instruction over 3-5 cycles and drives every select, enable and ALU-op line of the shared datapath. It sits beside the datapath and drives the ALU source-A, ALU source-B and result selectors, address select, IR/PC/regfile/memory enables. It handles memory wait states via mem_ready, traps on unsupported opcodes, and counts retired instructions.

Parameters:
CNT_WIDTH, 32, width of retired-instruction counter instret

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
op  input  7  opcode field of the instruction register
zero  input  1  ALU zero flag, valid in BEQ state
mem_ready  input  1  memory completes the current access this cycle
adr_src  output  1  memory address select: 0 = pc, 1 = alu_out
ir_write  output  1  instruction register / old_pc load enable
pc_write  output  1  pc load enable
mem_write  output  1  data memory write strobe
reg_write  output  1  register file write enable
alu_src_a  output  2  00 pc, 01 old_pc, 10 rs1 data
alu_src_b  output  2  00 rs2 data, 01 imm_ext, 10 constant 4
result_src  output  2  00 alu_out, 01 read data, 10 alu_result
alu_op  output  2  00 add, 01 subtract, 10 decode by funct3/funct7
instr_retired  output  1  one-cycle pulse when an instruction completes
illegal_instr  output  1  high while in TRAP
instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Clock is clk; reset is synchronous and active-high. Reset sets state to FETCH and instret to 0. Reset wins over every other event, including mid-instruction and TRAP.
- Outputs are Moore decode of the state, except ir_write/pc_write/mem_write, which are also gated by mem_ready, and pc_write, which also uses zero. Unlisted outputs are 0 in each state.
- After reset, outputs are the FETCH values: alu_src_b=10, result_src=10, all others 0, plus ir_write = pc_write = mem_ready.
- Internal pc_update and branch signals; pc_write = pc_update | (branch & zero).
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write = pc_update = mem_ready. Stay while !mem_ready; otherwise go to DECODE.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (precompute branch target). Next state by op:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - any other op -> TRAP
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00. Go to MEMREAD if op=0000011, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Stay while !mem_ready, then MEMWB.
- MEMWRITE: adr_src=1, result_src=00, mem_write=mem_ready. Stay while !mem_ready, then FETCH with retire.
- MEMWB: result_src=01, reg_write=1. Go to FETCH with retire.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Go to ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Go to ALUWB.
- ALUWB: result_src=00, reg_write=1. Go to FETCH with retire.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Go to FETCH with retire, taken or not.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Go to ALUWB (writes link register); ALUWB retires.
- TRAP: illegal_instr=1; all enables 0. Sticky until reset; no retire.
- Retire: instr_retired=1 in the cycle the state leaves for FETCH. instret increments on the following edge and wraps 2^CNT_WIDTH-1 -> 0.
- mem_ready deasserted forever: FSM holds in FETCH/MEMREAD/MEMWRITE with no enables asserted. This is not an error.
- Never drive both mem_write and reg_write in one cycle. alu_src_a/alu_src_b encoding 11 is never produced.

Decomposition:
- Shared package (riscv_defines): state encoding (4-bit, 12 states), opcode constants OP_LW/OP_SW/OP_R/OP_I/OP_BEQ/OP_JAL, select encodings SRC_A_*, SRC_B_*, RES_*, ALUOP_*.
- Sub-module: none; the funct-level ALU decoder remains a separate existing block fed by alu_op.

Test Plan:
- Reset held 2 cycles with mem_ready=1 -> state FETCH, ir_write=1, pc_write=1, alu_src_b=10, result_src=10, instret=0, illegal_instr=0.
- op=0110011, mem_ready=1 -> FETCH, DECODE, EXECUTER (alu_op=10, alu_src_a=10, alu_src_b=00), ALUWB (reg_write=1, instr_retired=1); instret 0->1; 4 cycles total.
- op=0000011, mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles with adr_src=1, then MEMWB (result_src=01, reg_write=1); 8 cycles total; one retire.
- op=1100011: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0. Both cases return to FETCH with instr_retired=1.
- op=1111111 -> TRAP after DECODE, illegal_instr=1 for 10 cycles, no enables, instret unchanged; reset returns to FETCH.
- Preload instret to all-ones (CNT_WIDTH=4, 15 retires) then 1 more R-type -> instret=0; reset asserted during EXECUTEI -> next cycle FETCH, no retire pulse.
